wb_trace_checker: RTL and testbench
===================================

// Module: wb_trace_checker
// PURPOSE
// - Sits directly downstream of the cpu core's writeback debug port; consumes debug_wb_* every cycle.
// - Queues retired register writes and compares them in order against a golden trace stream.
// - Reports PASS/FAIL, the first mismatch and a match count, so the top-level bench needs no $monitor diffing.
// PARAMETERS
// - FIFO_DEPTH  8             DUT-event queue depth; power of two, >=2.
// - END_PC      32'hBFC0_0100 debug_wb_pc value that marks end of program.
// - TIMEOUT     1024          watchdog limit in cycles; used only with TRACE_CHK_WATCHDOG_EN.
// PORTS
// - clk                input   1   rising-edge clock.
// - rst                input   1   asynchronous, active-low reset.
// - debug_wb_pc        input   32  PC of the instruction in writeback.
// - debug_wb_rf_wen    input   1   register-file write enable in writeback.
// - debug_wb_rf_addr   input   5   destination register.
// - debug_wb_rf_wdata  input   32  write data.
// - ref_valid          input   1   golden entry available.
// - ref_ready          output  1   golden entry consumed this cycle.
// - ref_pc/ref_wdata   input   32  golden PC and write data.
// - ref_addr           input   5   golden destination register.
// - chk_done           output  1   sticky: verdict reached.
// - chk_pass           output  1   sticky: valid only when chk_done=1.
// - err_code           output  2   0 none, 1 mismatch, 2 overflow, 3 timeout.
// - err_pc             output  32  PC of the first failing DUT event.
// - err_exp_wdata      output  32  golden wdata at the first mismatch.
// - err_got_wdata      output  32  DUT wdata at the first mismatch.
// - match_cnt          output  32  number of matched events.
// - fifo_level         output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - All outputs are 0. FIFO is empty. State is RUN.
//   - Asserting reset mid-run discards queued events and any verdict.
// - Event:
//   - A cycle with debug_wb_rf_wen=1 and debug_wb_rf_addr!=0 pushes {pc,addr,wdata} into the FIFO.
//   - Writes to $0 are ignored.
//   - Pushes happen only in state RUN.
// - Compare:
//   - ref_ready = (state==RUN || state==DRAIN) && !empty, combinationally.
//   - When ref_valid && ref_ready, the FIFO head is compared with ref_* on all three fields.
//   - Equal: pop the head and increment match_cnt on the same edge.
//   - Any field differs: pop nothing, latch err_pc=head.pc, err_exp_wdata=ref_wdata, err_got_wdata=head.wdata, err_code=1; state goes to FAIL.
// - Simultaneous push and pop: allowed, including when the FIFO is full; fifo_level is unchanged.
// - Overflow: push while full with no pop in the same cycle.
//   - err_code=2, err_pc=the incoming pc, state goes to FAIL; the event is dropped.
// - FSM:
//   - RUN -> DRAIN when debug_wb_pc==END_PC. An event in that same cycle is still pushed.
//   - DRAIN -> PASS when the FIFO is empty. Golden entries left unconsumed are not an error.
//   - RUN or DRAIN -> FAIL on mismatch, overflow or timeout. First error wins; later errors do not overwrite err_*.
//   - PASS and FAIL are terminal until reset. chk_done=1; chk_pass=1 only in PASS. ref_ready=0.
//   - Priority within one cycle: mismatch > overflow > END_PC transition.
// - Latency: the verdict is registered one cycle after the deciding compare or push.
// - match_cnt saturates at 32'hFFFF_FFFF.
// CONFIGURATION
// - TRACE_CHK_WATCHDOG_EN defined:
//   - A 32-bit idle counter runs in RUN and DRAIN. It clears on every push or pop and increments otherwise.
//   - When it reaches TIMEOUT: err_code=3, err_pc=debug_wb_pc, state goes to FAIL.
// - TRACE_CHK_WATCHDOG_EN undefined:
//   - No counter is built; err_code never takes the value 3; TIMEOUT is unused.
// TESTING
// - Match:
//   - Stimulus: 3 writes ($8=1, $9=2, $10=3) with identical golden entries, then pc=END_PC.
//   - Response: match_cnt=3, chk_done=1, chk_pass=1, err_code=0.
// - Mismatch:
//   - Stimulus: golden $9=2, DUT writes $9=5 at pc 32'hBFC0_0004.
//   - Response: err_code=1, err_pc=BFC0_0004, err_exp_wdata=2, err_got_wdata=5, chk_pass=0.
// - $0 filter:
//   - Stimulus: DUT writes $0=7 with no golden entry, then END_PC.
//   - Response: fifo_level stays 0; PASS.
// - Overflow:
//   - Stimulus: ref_valid=0, FIFO_DEPTH+1 consecutive writes.
//   - Response: err_code=2 on the 9th push (default depth); fifo_level=8.
// - Full push+pop:
//   - Stimulus: FIFO full; same cycle a new write and a matching ref.
//   - Response: level stays 8; no error.
// - Reset mid-run:
//   - Stimulus: rst=0 with 4 events queued.
//   - Response: fifo_level=0, match_cnt=0 immediately.
//   - With TRACE_CHK_WATCHDOG_EN: 1024 idle cycles -> err_code=3.

Source files
------------

// File: rtl/wb_trace_checker.sv
// wb_trace_checker
// Watches the core's writeback debug port, queues every retired register
// write (ignoring $0) and checks it, in order, against a golden trace stream.
// Outputs a sticky PASS/FAIL verdict, the first failing event and a running
// match count.
//
// Build option: define TRACE_CHK_WATCHDOG_EN to add an idle watchdog that
// fails the run after TIMEOUT cycles without a push or a pop. Without it no
// counter exists and err_code never reports a timeout.
module wb_trace_checker #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'hBFC0_0100,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   debug_wb_pc,
  input  logic                          debug_wb_rf_wen,
  input  logic [4:0]                    debug_wb_rf_addr,
  input  logic [31:0]                   debug_wb_rf_wdata,
  input  logic                          ref_valid,
  output logic                          ref_ready,
  input  logic [31:0]                   ref_pc,
  input  logic [4:0]                    ref_addr,
  input  logic [31:0]                   ref_wdata,
  output logic                          chk_done,
  output logic                          chk_pass,
  output logic [1:0]                    err_code,
  output logic [31:0]                   err_pc,
  output logic [31:0]                   err_exp_wdata,
  output logic [31:0]                   err_got_wdata,
  output logic [31:0]                   match_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_PASS  = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Event storage: one array per field, indexed by the ring pointers.
  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [4:0]  addr_mem  [FIFO_DEPTH];
  logic [31:0] wdata_mem [FIFO_DEPTH];

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [1:0]    err_code_reg;
  logic [31:0]   err_pc_reg, err_exp_reg, err_got_reg;
  logic [31:0]   match_cnt_reg;

  logic        active;
  logic        empty, full;
  logic [31:0] head_pc, head_wdata;
  logic [4:0]  head_addr;
  logic        cmp_fire, fields_eq;
  logic        pop, mismatch;
  logic        push_req, push, overflow;
  logic        timeout_hit;

  assign active     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign empty      = (level_reg == '0);
  assign full       = (level_reg == FULL_LEVEL);

  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_addr  = addr_mem[rd_ptr_reg];
  assign head_wdata = wdata_mem[rd_ptr_reg];

  assign ref_ready  = active && !empty;
  assign cmp_fire   = ref_valid && ref_ready;
  assign fields_eq  = (head_pc == ref_pc) && (head_addr == ref_addr) &&
                      (head_wdata == ref_wdata);
  assign pop        = cmp_fire && fields_eq;
  assign mismatch   = cmp_fire && !fields_eq;

  // Only real register writes count; $0 writes are architectural no-ops.
  assign push_req   = (state_reg == ST_RUN) && debug_wb_rf_wen &&
                      (debug_wb_rf_addr != 5'd0);
  // A full queue still accepts a push when the head leaves on the same edge.
  assign overflow   = push_req && full && !pop;
  assign push       = push_req && !overflow;

`ifdef TRACE_CHK_WATCHDOG_EN
  logic [31:0] idle_cnt_reg;

  assign timeout_hit = active && (idle_cnt_reg >= 32'(TIMEOUT));

  // Idle watchdog: counts cycles with neither a push nor a pop while checking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_reg <= '0;
    end else if (!active || push || pop) begin
      idle_cnt_reg <= '0;
    end else if (idle_cnt_reg != 32'hFFFF_FFFF) begin
      idle_cnt_reg <= idle_cnt_reg + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  wire unused_timeout = ^(32'(TIMEOUT));
`endif

  // Verdict FSM next state; error sources are ranked so the highest wins.
  always_comb begin
    state_next = state_reg;
    if (active) begin
      if (mismatch || overflow || timeout_hit) begin
        state_next = ST_FAIL;
      end else if ((state_reg == ST_RUN) && (debug_wb_pc == END_PC)) begin
        state_next = ST_DRAIN;
      end else if ((state_reg == ST_DRAIN) && empty) begin
        state_next = ST_PASS;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Queue storage write port; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= debug_wb_pc;
      addr_mem[wr_ptr_reg]  <= debug_wb_rf_addr;
      wdata_mem[wr_ptr_reg] <= debug_wb_rf_wdata;
    end
  end

  // Queue pointers and occupancy; push+pop together leaves the level alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // First-error capture; the FSM leaves the active states on any error, so
  // later errors can never reach this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_code_reg <= ERR_NONE;
      err_pc_reg   <= '0;
      err_exp_reg  <= '0;
      err_got_reg  <= '0;
    end else if (mismatch) begin
      err_code_reg <= ERR_MISMATCH;
      err_pc_reg   <= head_pc;
      err_exp_reg  <= ref_wdata;
      err_got_reg  <= head_wdata;
    end else if (overflow) begin
      err_code_reg <= ERR_OVERFLOW;
      err_pc_reg   <= debug_wb_pc;
    end else if (timeout_hit) begin
      err_code_reg <= ERR_TIMEOUT;
      err_pc_reg   <= debug_wb_pc;
    end
  end

  // Saturating count of matched events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_reg <= '0;
    end else if (pop && (match_cnt_reg != 32'hFFFF_FFFF)) begin
      match_cnt_reg <= match_cnt_reg + 32'd1;
    end
  end

  assign chk_done      = (state_reg == ST_PASS) || (state_reg == ST_FAIL);
  assign chk_pass      = (state_reg == ST_PASS);
  assign err_code      = err_code_reg;
  assign err_pc        = err_pc_reg;
  assign err_exp_wdata = err_exp_reg;
  assign err_got_wdata = err_got_reg;
  assign match_cnt     = match_cnt_reg;
  assign fifo_level    = level_reg;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker
// Directed scenarios plus randomized traffic for wb_trace_checker, every
// cycle compared against a queue-based reference model of the checker.
module tb_wb_trace_checker;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'hBFC0_0100;

  localparam int S_RUN   = 0;
  localparam int S_DRAIN = 1;
  localparam int S_PASS  = 2;
  localparam int S_FAIL  = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_addr;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_addr;
  logic [31:0] ref_wdata;
  logic        chk_done;
  logic        chk_pass;
  logic [1:0]  err_code;
  logic [31:0] err_pc;
  logic [31:0] err_exp_wdata;
  logic [31:0] err_got_wdata;
  logic [31:0] match_cnt;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ev_t         m_q[$];
  int          m_state;
  logic [31:0] m_match, m_code, m_err_pc, m_err_exp, m_err_got;

  always #5 clk = ~clk;

  wb_trace_checker #(.FIFO_DEPTH(DEPTH), .END_PC(END_PC), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
    .ref_addr(ref_addr), .ref_wdata(ref_wdata),
    .chk_done(chk_done), .chk_pass(chk_pass), .err_code(err_code),
    .err_pc(err_pc), .err_exp_wdata(err_exp_wdata), .err_got_wdata(err_got_wdata),
    .match_cnt(match_cnt), .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state   = S_RUN;
    m_match   = 0;
    m_code    = 0;
    m_err_pc  = 0;
    m_err_exp = 0;
    m_err_got = 0;
  endtask

  // Apply the checker's rules to the inputs currently on the pins.
  task automatic model_step();
    bit active, rdy, popx, mism, want;
    int pre, nstate;
    active = (m_state == S_RUN) || (m_state == S_DRAIN);
    pre    = m_q.size();
    rdy    = active && (pre > 0);
    popx   = 0;
    mism   = 0;
    nstate = m_state;
    if (ref_valid && rdy) begin
      if (m_q[0].pc == ref_pc && m_q[0].addr == ref_addr && m_q[0].wdata == ref_wdata)
        popx = 1;
      else
        mism = 1;
    end
    want = (m_state == S_RUN) && debug_wb_rf_wen && (debug_wb_rf_addr != 0);
    if (mism) begin
      m_code = 1; m_err_pc = m_q[0].pc; m_err_exp = ref_wdata; m_err_got = m_q[0].wdata;
      nstate = S_FAIL;
    end else if (want && pre == DEPTH && !popx) begin
      m_code = 2; m_err_pc = debug_wb_pc;
      nstate = S_FAIL;
    end else if (m_state == S_RUN && debug_wb_pc == END_PC) begin
      nstate = S_DRAIN;
    end else if (m_state == S_DRAIN && pre == 0) begin
      nstate = S_PASS;
    end
    if (popx) begin
      void'(m_q.pop_front());
      if (m_match != 32'hFFFF_FFFF) m_match = m_match + 1;
    end
    if (want && (pre < DEPTH || popx))
      m_q.push_back({debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata});
    m_state = nstate;
  endtask

  task automatic compare_all();
    bit rdy_exp;
    rdy_exp = (m_state == S_RUN || m_state == S_DRAIN) && (m_q.size() > 0);
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("match_cnt", match_cnt, m_match);
    check("chk_done", 32'(chk_done), 32'(m_state == S_PASS || m_state == S_FAIL));
    check("chk_pass", 32'(chk_pass), 32'(m_state == S_PASS));
    check("err_code", 32'(err_code), m_code);
    check("err_pc", err_pc, m_err_pc);
    check("err_exp_wdata", err_exp_wdata, m_err_exp);
    check("err_got_wdata", err_got_wdata, m_err_got);
    check("ref_ready", 32'(ref_ready), 32'(rdy_exp));
  endtask

  task automatic step(input logic [31:0] pc, input logic wen, input logic [4:0] addr,
                      input logic [31:0] wd, input logic rv, input logic [31:0] rpc,
                      input logic [4:0] raddr, input logic [31:0] rwd);
    debug_wb_pc = pc; debug_wb_rf_wen = wen; debug_wb_rf_addr = addr; debug_wb_rf_wdata = wd;
    ref_valid = rv; ref_pc = rpc; ref_addr = raddr; ref_wdata = rwd;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Idle cycle, optionally offering the golden entry that matches the head.
  task automatic idle_step(input bit give_ref);
    if (give_ref && m_q.size() > 0)
      step(32'h0, 0, 0, 0, 1, m_q[0].pc, m_q[0].addr, m_q[0].wdata);
    else
      step(32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !(m_state == S_PASS || m_state == S_FAIL); i++)
      idle_step(1);
    check("done_reached", 32'(chk_done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    debug_wb_pc = 0; debug_wb_rf_wen = 0; debug_wb_rf_addr = 0; debug_wb_rf_wdata = 0;
    ref_valid = 0; ref_pc = 0; ref_addr = 0; ref_wdata = 0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    logic [31:0] rpc, rwd, pcv;
    logic [4:0]  raddr;

    // Match: three writes, matching golden entries, then end of program.
    do_reset();
    step(32'hBFC0_0000, 1, 5'd8,  32'd1, 0, 0, 0, 0);
    step(32'hBFC0_0004, 1, 5'd9,  32'd2, 0, 0, 0, 0);
    step(32'hBFC0_0008, 1, 5'd10, 32'd3, 0, 0, 0, 0);
    check("match_level3", 32'(fifo_level), 32'd3);
    step(32'h0, 0, 0, 0, 1, 32'hBFC0_0000, 5'd8,  32'd1);
    step(32'h0, 0, 0, 0, 1, 32'hBFC0_0004, 5'd9,  32'd2);
    step(32'h0, 0, 0, 0, 1, 32'hBFC0_0008, 5'd10, 32'd3);
    step(END_PC, 0, 0, 0, 0, 0, 0, 0);
    wait_done();
    check("match_cnt3", match_cnt, 32'd3);
    check("match_pass", 32'(chk_pass), 32'd1);
    check("match_code", 32'(err_code), 32'd0);
    $display("scenario match: match_cnt=%0d pass=%0d", match_cnt, chk_pass);

    // Mismatch: DUT wrote 5 where golden says 2.
    do_reset();
    step(32'hBFC0_0004, 1, 5'd9, 32'd5, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 1, 32'hBFC0_0004, 5'd9, 32'd2);
    check("mm_code", 32'(err_code), 32'd1);
    check("mm_pc", err_pc, 32'hBFC0_0004);
    check("mm_exp", err_exp_wdata, 32'd2);
    check("mm_got", err_got_wdata, 32'd5);
    check("mm_pass", 32'(chk_pass), 32'd0);
    check("mm_done", 32'(chk_done), 32'd1);
    $display("scenario mismatch: err_code=%0d err_pc=%h", err_code, err_pc);

    // $0 filter.
    do_reset();
    step(32'hBFC0_0010, 1, 5'd0, 32'd7, 0, 0, 0, 0);
    check("zero_level", 32'(fifo_level), 32'd0);
    step(END_PC, 0, 0, 0, 0, 0, 0, 0);
    wait_done();
    check("zero_pass", 32'(chk_pass), 32'd1);
    $display("scenario zero-reg: level=%0d pass=%0d", fifo_level, chk_pass);

    // Overflow: DEPTH+1 writes with no golden stream.
    do_reset();
    for (int i = 0; i <= DEPTH; i++)
      step(32'h0040_0000 + 32'(i * 4), 1, 5'(i + 1), 32'(i * 3 + 11), 0, 0, 0, 0);
    check("ovf_code", 32'(err_code), 32'd2);
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_pc", err_pc, 32'h0040_0000 + 32'(DEPTH * 4));
    $display("scenario overflow: err_code=%0d level=%0d", err_code, fifo_level);

    // Full queue with simultaneous push and matching pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(32'h0050_0000 + 32'(i * 4), 1, 5'(i + 3), 32'(i * 7 + 1), 0, 0, 0, 0);
    check("full_level", 32'(fifo_level), 32'd8);
    step(32'h0050_1000, 1, 5'd31, 32'hDEAD_BEEF, 1, m_q[0].pc, m_q[0].addr, m_q[0].wdata);
    check("fpp_level", 32'(fifo_level), 32'd8);
    check("fpp_code", 32'(err_code), 32'd0);
    check("fpp_match", match_cnt, 32'd1);
    $display("scenario full-push-pop: level=%0d match=%0d", fifo_level, match_cnt);

    // Reset in the middle of a run.
    do_reset();
    step(32'h0060_0000, 1, 5'd4, 32'd44, 0, 0, 0, 0);
    idle_step(1);
    for (int i = 0; i < 4; i++)
      step(32'h0060_0010 + 32'(i * 4), 1, 5'(i + 12), 32'(i + 100), 0, 0, 0, 0);
    check("mid_level4", 32'(fifo_level), 32'd4);
    check("mid_match1", match_cnt, 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_match", match_cnt, 32'd0);
    check("rst_done", 32'(chk_done), 32'd0);
    $display("scenario reset-mid-run: level=%0d match=%0d", fifo_level, match_cnt);

    // Randomized traffic; the last run injects occasional golden corruption.
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        pcv = 32'h0040_0000 | ($urandom & 32'h0000_FFFC);
        if (m_q.size() > 0 && ($urandom % 4) != 0) begin
          rpc = m_q[0].pc; raddr = m_q[0].addr; rwd = m_q[0].wdata;
          if (run == 3 && ($urandom % 20) == 0) rwd = rwd ^ 32'h1;
          step(pcv, 1'($urandom % 2), 5'($urandom % 32), $urandom, 1, rpc, raddr, rwd);
        end else begin
          step(pcv, 1'($urandom % 2), 5'($urandom % 32), $urandom,
               1'($urandom % 2), $urandom, 5'($urandom % 32), $urandom);
        end
      end
      step(END_PC, 0, 0, 0, 0, 0, 0, 0);
      wait_done();
      $display("scenario random %0d: done=%0d pass=%0d err_code=%0d match=%0d",
               run, chk_done, chk_pass, err_code, match_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
